// File: rtl/pc_watch_unit_if.sv
// Bundle between the fetch observer (master) and pc_watch_unit (slave).
// It carries the run controls, the fetch PC and handshake, and the status and counter readback.
interface pc_watch_unit_if #(
   parameter int ADDR_W    = 32,
   parameter int NUM_WATCH = 2,
   parameter int CNT_W     = 32
);
   logic                 arm;
   logic                 clr;
   logic [ADDR_W-1:0]    pc;
   logic                 pc_valid;
   logic [2:0]           sel;
   logic                 signal;
   logic                 timeout;
   logic                 running;
   logic [NUM_WATCH-1:0] hit_mask;
   logic [CNT_W-1:0]     hit_cnt;
   logic [CNT_W-1:0]     cycle_cnt;
   logic [CNT_W-1:0]     fetch_cnt;
   logic [CNT_W-1:0]     stamp;

   modport master (
      output arm, clr, pc, pc_valid, sel,
      input  signal, timeout, running, hit_mask, hit_cnt, cycle_cnt, fetch_cnt, stamp
   );

   modport slave (
      input  arm, clr, pc, pc_valid, sel,
      output signal, timeout, running, hit_mask, hit_cnt, cycle_cnt, fetch_cnt, stamp
   );
endinterface

// File: rtl/pc_watch_unit.sv
// Fetch-PC watch monitor: per-channel address hit counters, a completion threshold, and a run timeout.
// Defining PC_WATCH_STAMP_EN adds a per-channel first-hit cycle stamp; without it, stamp reads 0.
//
// state   | meaning
// S_IDLE  | waiting for arm, counters hold (zero after clr/reset)
// S_RUN   | counting cycles, fetches and channel hits
// S_DONE  | channel 0 reached DONE_HITS, counters frozen
// S_TMO   | run hit TIMEOUT cycles, counters frozen
module pc_watch_unit #(
   parameter int                              ADDR_W      = 32,
   parameter int                              NUM_WATCH   = 2,
   parameter logic [NUM_WATCH*ADDR_W-1:0]     WATCH_ADDRS = {32'h00400080, 32'h0040007c},
   parameter int                              DONE_HITS   = 1,
   parameter int                              CNT_W       = 32,
   parameter int                              TIMEOUT     = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   pc_watch_unit_if.slave    bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_TMO  = 2'd3;

   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_HITS - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

   logic [1:0]           state_q, state_d;
   logic [NUM_WATCH-1:0] hit_w;
   logic [NUM_WATCH-1:0] hit_mask_q, hit_mask_d;
   logic [CNT_W-1:0]     hit_cnt_q [NUM_WATCH];
   logic [CNT_W-1:0]     hit_cnt_d [NUM_WATCH];
   logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]     fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0]     hit_sel;
   logic                 in_run;
   logic                 done_w;
   logic                 tmo_w;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign in_run = (state_q == S_RUN);

   always_comb begin
      hit_w = '0;
      for (int i = 0; i < NUM_WATCH; i++) begin
         hit_w[i] = in_run && bus.pc_valid && (bus.pc == WATCH_ADDRS[i*ADDR_W +: ADDR_W]);
      end
   end

   // Thresholds compare against the pre-increment value so the exit happens on the hit itself.
   assign done_w = hit_w[0] && (hit_cnt_q[0] == DONE_LAST);
   assign tmo_w  = (TIMEOUT != 0) && in_run && (cycle_cnt_q == TMO_LAST);

   always_comb begin
      state_d     = state_q;
      hit_mask_d  = hit_mask_q;
      cycle_cnt_d = cycle_cnt_q;
      fetch_cnt_d = fetch_cnt_q;
      for (int i = 0; i < NUM_WATCH; i++) begin
         hit_cnt_d[i] = hit_cnt_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (bus.arm) state_d = S_RUN;
         end
         S_RUN: begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            if (bus.pc_valid) fetch_cnt_d = sat_inc(fetch_cnt_q);
            for (int i = 0; i < NUM_WATCH; i++) begin
               if (hit_w[i]) begin
                  hit_cnt_d[i]  = sat_inc(hit_cnt_q[i]);
                  hit_mask_d[i] = 1'b1;
               end
            end
            if (done_w)     state_d = S_DONE;
            else if (tmo_w) state_d = S_TMO;
         end
         default: ;
      endcase

      if (bus.clr) begin
         state_d     = S_IDLE;
         hit_mask_d  = '0;
         cycle_cnt_d = '0;
         fetch_cnt_d = '0;
         for (int i = 0; i < NUM_WATCH; i++) begin
            hit_cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         hit_mask_q  <= '0;
         cycle_cnt_q <= '0;
         fetch_cnt_q <= '0;
         for (int i = 0; i < NUM_WATCH; i++) begin
            hit_cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         hit_mask_q  <= hit_mask_d;
         cycle_cnt_q <= cycle_cnt_d;
         fetch_cnt_q <= fetch_cnt_d;
         for (int i = 0; i < NUM_WATCH; i++) begin
            hit_cnt_q[i] <= hit_cnt_d[i];
         end
      end
   end

   always_comb begin
      hit_sel = '0;
      for (int i = 0; i < NUM_WATCH; i++) begin
         if (bus.sel == 3'(i)) hit_sel = hit_cnt_q[i];
      end
   end

`ifdef PC_WATCH_STAMP_EN
   logic [CNT_W-1:0] stamp_q [NUM_WATCH];
   logic [CNT_W-1:0] stamp_d [NUM_WATCH];
   logic [CNT_W-1:0] stamp_sel;

   // A stamp is taken only on the hit that first sets the channel's mask bit.
   always_comb begin
      for (int i = 0; i < NUM_WATCH; i++) begin
         stamp_d[i] = stamp_q[i];
         if (hit_w[i] && !hit_mask_q[i]) stamp_d[i] = cycle_cnt_q;
         if (bus.clr) stamp_d[i] = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_WATCH; i++) begin
            stamp_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_WATCH; i++) begin
            stamp_q[i] <= stamp_d[i];
         end
      end
   end

   always_comb begin
      stamp_sel = '0;
      for (int i = 0; i < NUM_WATCH; i++) begin
         if (bus.sel == 3'(i)) stamp_sel = stamp_q[i];
      end
   end

   assign bus.stamp = stamp_sel;
`else
   assign bus.stamp = '0;
`endif

   assign bus.signal    = (state_q == S_DONE);
   assign bus.timeout   = (state_q == S_TMO);
   assign bus.running   = in_run;
   assign bus.hit_mask  = hit_mask_q;
   assign bus.hit_cnt   = hit_sel;
   assign bus.cycle_cnt = cycle_cnt_q;
   assign bus.fetch_cnt = fetch_cnt_q;

endmodule
